fifo_pro: RTL and testbench

Parametrised synchronous FIFO, the successor of the fixed 8-bit/16-entry FIFO used by the current verification environment. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow error pulses. A compile-time first-word-fall-through read mode is available. Sits between a producer and consumer in one clock domain and is driven by the same class-based environment through an extended interface.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 24 ++
 rtl/fifo_pro.sv | 117 +++++++++++
 tb/tb_fifo_pro.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, count-width helper and status bundle
// for fifo_pro and its verification environment.
package fifo_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DWIDTH x DEPTH storage, one sync write port and
// one async read port, no reset.
module fifo_ram #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_pro.sv
// fifo_pro: parametrised sync FIFO with count, thresholds and error
// pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_pro
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [DWIDTH-1:0]          data_in,
  output logic [DWIDTH-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_status_t  status_q, status_d;
  logic          wr_ok, rd_ok;
  logic [DWIDTH-1:0] ram_rdata;

  // A full FIFO still takes a write when a read frees a slot.
  assign rd_ok = rd && !status_q.empty;
  assign wr_ok = wr && (!status_q.full || rd);

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clock (clock),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    status_d.empty        = (count_d == '0);
    status_d.full         = (count_d == FULL_C);
    status_d.almost_empty = (count_d <= AE_C);
    status_d.almost_full  = (count_d >= AF_C);
    status_d.overflow     = wr && !wr_ok;
    status_d.underflow    = rd && !rd_ok;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '{empty: 1'b1, full: 1'b0,
                    almost_empty: 1'b1, almost_full: 1'b0,
                    overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = status_q.empty ? '0 : ram_rdata;
`else
  logic [DWIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_ok) dout_d = ram_rdata;
  end

  always_ff @(posedge clock) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

  assign count        = count_q;
  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_fifo_pro.sv
// tb_fifo_pro: directed self-checking bench for fifo_pro (DEPTH=16).
// Handles both FIFO_FWFT_EN and standard read modes.
module tb_fifo_pro;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       empty, full, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;

  fifo_pro dut (
    .clock        (clock),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    wr = 1'b1;
    data_in = v;
    step();
    wr = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] v);
`ifdef FIFO_FWFT_EN
    check(tag, 32'(data_out), 32'(v));
    rd = 1'b1;
    step();
    rd = 1'b0;
`else
    rd = 1'b1;
    step();
    rd = 1'b0;
    check(tag, 32'(data_out), 32'(v));
`endif
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);

    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      check("fill_count", 32'(count), 32'(i));
      check("fill_af", 32'(almost_full), 32'(i >= 14));
      check("fill_ae", 32'(almost_empty), 32'(i <= 2));
      check("fill_empty", 32'(empty), 32'd0);
    end
    check("full_flag", 32'(full), 32'd1);

    // Rejected write on a full FIFO.
    push(8'hEE);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    step();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Simultaneous write/read while full.
    wr = 1'b1;
    data_in = 8'hAA;
`ifdef FIFO_FWFT_EN
    check("wr_rd_full_head", 32'(data_out), 32'h01);
    rd = 1'b1;
    step();
`else
    rd = 1'b1;
    step();
    check("wr_rd_full_head", 32'(data_out), 32'h01);
`endif
    wr = 1'b0;
    rd = 1'b0;
    check("wr_rd_full_cnt", 32'(count), 32'd16);
    check("wr_rd_full_ovf", 32'(overflow), 32'd0);

    for (int i = 2; i <= 16; i++) pop_check("drain", 8'(i));
    pop_check("drain_aa", 8'hAA);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Back-to-back rejected reads.
    rd = 1'b1;
    step();
    check("unf_pulse1", 32'(underflow), 32'd1);
    step();
    rd = 1'b0;
    check("unf_pulse2", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
`ifdef FIFO_FWFT_EN
    check("unf_dout", 32'(data_out), 32'd0);
`else
    check("unf_dout", 32'(data_out), 32'hAA);
`endif
    step();
    check("unf_clear", 32'(underflow), 32'd0);

    // Write and read together while empty.
    wr = 1'b1;
    rd = 1'b1;
    data_in = 8'h55;
    step();
    wr = 1'b0;
    rd = 1'b0;
    check("wr_rd_empty_unf", 32'(underflow), 32'd1);
    check("wr_rd_empty_cnt", 32'(count), 32'd1);
`ifndef FIFO_FWFT_EN
    check("wr_rd_empty_dout", 32'(data_out), 32'hAA);
`endif
    pop_check("wr_rd_empty_pop", 8'h55);

    for (int i = 0; i < 20; i++) begin
      push(8'(8'h20 + i));
      check("alt_cnt1", 32'(count), 32'd1);
      pop_check("alt_data", 8'(8'h20 + i));
      check("alt_cnt0", 32'(count), 32'd0);
    end

    for (int i = 0; i < 9; i++) push(8'(8'h30 + i));
    check("pre_rst_count", 32'(count), 32'd9);
    rst = 1'b1;
    wr = 1'b1;
    rd = 1'b1;
    data_in = 8'h99;
    step();
    rst = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ae", 32'(almost_empty), 32'd1);
    check("mid_rst_dout", 32'(data_out), 32'd0);
    push(8'h77);
    check("post_rst_count", 32'(count), 32'd1);
    pop_check("post_rst_data", 8'h77);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
